uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
Parametrised UART receiver that generalises the fixed 8N1 / 9600-baud / 4x receiver. Adds:
- configurable data width, parity and stop-bit count
- configurable oversampling, with 3-sample majority voting
- false-start rejection
- framing-error, parity-error, break and overrun detection
- a small receive FIFO with a valid/ready output handshake

It sits between the board RxD pin and the CPU's memory-mapped I/O or loader logic.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bits/s
OVERSAMPLE, 16, sample ticks per bit; must be an even number ≥ 4
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries; power of two ≥ 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
rxd  in  1  serial line input; asynchronous; idles high
rx_data  out  DATA_BITS  data at FIFO head, LSB = first bit received
rx_parity_err  out  1  head entry had a parity mismatch
rx_frame_err  out  1  head entry had a stop bit sampled low
rx_break  out  1  head entry is a break
rx_valid  out  1  FIFO is non-empty
rx_ready  in  1  consumer accepts the head entry
overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full
busy  out  1  receiver FSM is not in IDLE

Behaviour:
Input synchroniser and tick generator:
- rxd passes through a 2-flop synchroniser; both flops reset to 1.
- The tick generator counts 0..DIV-1, where DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE).
- tick is a one-clk pulse when the count reaches DIV-1; the counter then wraps to 0. The generator is free-running.
- Elaboration fails if DIV < 2.
- All FSM and sample-counter updates occur only on tick cycles. FIFO pop and the outputs run every clk.

Bit sampling:
- The sample counter scnt runs 0..OVERSAMPLE-1 within each bit.
- The bit value is the majority of the synchronised rxd at scnt = M-1, M and M+1, where M = OVERSAMPLE/2.
- The value resolves at scnt = M+1.

FSM states and transitions:
- IDLE: synced rxd == 0 on a tick → START; scnt = 1.
- START: at resolve, majority == 1 → IDLE (false start, nothing pushed). Otherwise, at scnt = OVERSAMPLE-1 → DATA; bit index = 0.
- DATA: bits are shifted in LSB first. After bit DATA_BITS-1 completes → PARITY if PARITY != 0, otherwise → STOP.
- PARITY: the received parity bit is compared with the computed value. Odd parity: XOR of data and parity bit must be 1. Even parity: that XOR must be 0. A mismatch sets perr.
- STOP: each stop bit is resolved at its mid-point. Any stop bit sampled 0 sets ferr.
- At resolve of the last stop bit, the word {brk, ferr, perr, data} is pushed to the FIFO, using the same tick. The FSM does not wait out the rest of the stop bit:
  - ferr == 0 → IDLE
  - ferr == 1 → BRKWAIT
- brk = ferr && data == 0 && no received bit (parity included) was 1.
- BRKWAIT: stays until synced rxd == 1 on a tick, then → IDLE. No further frames are pushed during a held-low line.

FIFO:
- First-word-fall-through. rx_valid = !empty, and the head fields are driven directly from the FIFO.
- Pop occurs when rx_valid && rx_ready.
- A push while full is dropped: FIFO contents are unchanged and overrun pulses high for one clk.
- Push and pop in the same cycle while full: the pop is applied first, the push is accepted, and there is no overrun.
- Pointers are log2(FIFO_DEPTH) bits plus one wrap bit.

Latency: rx_valid rises on the clk after the push tick when the FIFO was empty.

Reset:
- Applies asynchronously at any time, including mid-frame.
- FSM → IDLE, all counters → 0, FIFO empty, partial frame discarded.
- Output values during reset: rx_valid = 0, overrun = 0, busy = 0, rx_data = 0, all error flags = 0.

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants
  - the rx state encoding (IDLE, START, DATA, PARITY, STOP, BRKWAIT)
  - a divisor function shared with the future transmitter
- One sub-module, uart_rx_fifo: a synchronous FWFT FIFO with parameters WIDTH and DEPTH and ports push/pop/full/empty.
- The synchroniser, tick generator and FSM stay in uart_rx_core.

Test Plan:
Bench parameters are CLK_FREQ = 1_600_000, BAUD_RATE = 10_000, OVERSAMPLE = 16, which gives DIV = 10 and 160 clk per bit.
1. 8N1 frame 0x55, rx_ready = 1 → one accept with rx_data = 0x55, all error flags 0, busy low after the stop-bit mid-point.
2. PARITY = 2, frame 0xA3 sent with parity bit 1 (wrong; correct is 0) → rx_data = 0xA3, rx_parity_err = 1. The same frame with parity bit 0 → rx_parity_err = 0.
3. Glitch: rxd low for 60 clk, then high → no FIFO push, FSM returns to IDLE, rx_valid stays 0. A valid 0x3C sent afterwards is received correctly.
4. Frame 0x00 with rxd held low for 3 frame times → exactly one entry with rx_break = 1 and rx_frame_err = 1. After rxd returns high, frame 0x81 is received cleanly.
5. FIFO_DEPTH = 4, rx_ready = 0, send 0x01..0x05 → overrun pulses exactly once, at the 5th frame. Then raise rx_ready → 0x01, 0x02, 0x03, 0x04 are accepted in order and rx_valid drops afterwards.
6. Assert rst_n low mid-way through data bit 3 of 0x7E, release, then send 0x99 → only 0x99 is received and no error flags are set.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks.
//   PARITY_*    parity mode encodings used by the PARITY parameter
//   rx_state_t  receiver FSM state encoding
//   baud_div()  clocks per oversample tick, shared with the transmitter
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_BRKWAIT = 3'd5
  } rx_state_t;

  function automatic int baud_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (dropped when full unless a pop happens too)
//   push_data    entry to write
//   pop          remove the head entry (ignored when empty)
//   head_data    current head entry, valid while !empty
//   full, empty  occupancy flags
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot in the same cycle, so push-while-full-and-pop is accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Storage is cleared so the head reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with majority voting, error
// detection and a small receive FIFO.
//   clk, rst_n      clock, asynchronous active-low reset
//   rxd             asynchronous serial input, idles high
//   rx_data         data of the FIFO head entry, LSB first received
//   rx_parity_err   head entry had a parity mismatch
//   rx_frame_err    head entry had a low stop bit
//   rx_break        head entry is a break
//   rx_valid        FIFO non-empty
//   rx_ready        consumer takes the head entry
//   overrun         one-clk pulse when a completed frame was dropped
//   busy            receiver FSM not idle
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | line idle, waiting for a low sample
// ST_START   | qualifying the start bit; a high majority is a false start
// ST_DATA    | shifting in data bits LSB first
// ST_PARITY  | sampling and checking the parity bit
// ST_STOP    | sampling stop bit(s); entry pushed at last stop mid-point
// ST_BRKWAIT | after a framing error, waiting for the line to go high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int BIW = $clog2(DATA_BITS);
  localparam int FW  = DATA_BITS + 3;

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_core: clock/baud divisor must be at least 2");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("uart_rx_core: OVERSAMPLE must be even and >= 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_db
    $error("uart_rx_core: DATA_BITS must be 5..9");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_par
    $error("uart_rx_core: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo
    $error("uart_rx_core: FIFO_DEPTH must be a power of two >= 2");
  end

  logic                 rxd_meta;
  logic                 rxd_s;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  rx_state_t            state;
  logic [SW-1:0]        scnt;
  logic [BIW-1:0]       bit_idx;
  logic                 stop_idx;
  logic                 samp_a;
  logic                 samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 par_one;
  logic                 maj;
  logic                 resolve;
  logic                 bit_end;
  logic                 last_stop;
  logic                 ferr_next;
  logic                 brk_next;
  logic                 push;
  logic [FW-1:0]        push_word;
  logic [FW-1:0]        head_word;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // Majority of the samples at M-1, M and the live one at M+1.
  assign maj       = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);
  assign resolve   = (scnt == SW'(M + 1));
  assign bit_end   = (scnt == SW'(OVERSAMPLE - 1));
  assign last_stop = (stop_idx == (STOP_BITS == 2));
  assign ferr_next = ferr | ~maj;
  assign brk_next  = ferr_next && (shreg == '0) && !par_one;

  // The entry is pushed on the resolve tick of the last stop bit.
  assign push      = tick && (state == ST_STOP) && resolve && last_stop;
  assign push_word = {brk_next, ferr_next, perr, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      scnt     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      par_one  <= 1'b0;
    end else if (tick) begin
      if (scnt == SW'(M - 1)) samp_a <= rxd_s;
      if (scnt == SW'(M))     samp_b <= rxd_s;
      case (state)
        ST_IDLE: begin
          if (!rxd_s) begin
            state   <= ST_START;
            scnt    <= SW'(1);
            perr    <= 1'b0;
            ferr    <= 1'b0;
            par_one <= 1'b0;
          end
        end
        ST_START: begin
          if (resolve && maj) begin
            state <= ST_IDLE;
            scnt  <= '0;
          end else if (bit_end) begin
            state   <= ST_DATA;
            scnt    <= '0;
            bit_idx <= '0;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        ST_DATA: begin
          if (resolve) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            scnt <= '0;
            if (bit_idx == BIW'(DATA_BITS - 1)) begin
              state    <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + BIW'(1);
            end
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        ST_PARITY: begin
          if (resolve) begin
            par_one <= maj;
            // ^{data, parity} is 1 for a good odd-parity frame, 0 for even.
            perr    <= (PARITY == PARITY_ODD) ? ~(^shreg ^ maj) : (^shreg ^ maj);
          end
          if (bit_end) begin
            state    <= ST_STOP;
            scnt     <= '0;
            stop_idx <= 1'b0;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        ST_STOP: begin
          if (resolve) begin
            ferr <= ferr_next;
            if (last_stop) begin
              state <= ferr_next ? ST_BRKWAIT : ST_IDLE;
              scnt  <= '0;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end else if (bit_end) begin
            scnt     <= '0;
            stop_idx <= 1'b1;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        ST_BRKWAIT: begin
          if (rxd_s) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          scnt  <= '0;
        end
      endcase
    end
  end

  assign pop = rx_valid && rx_ready;

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head_data (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else        overrun <= push && fifo_full && !pop;
  end

  assign rx_valid = !fifo_empty;
  assign {rx_break, rx_frame_err, rx_parity_err, rx_data} = head_word;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  localparam int BIT_CLK = 160;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;
  logic rx_ready_a = 1'b0;
  logic rx_ready_b = 1'b1;
  int   rdy_mode_a = 1;

  logic [7:0] rx_data_a, rx_data_b;
  logic rx_parity_err_a, rx_frame_err_a, rx_break_a, rx_valid_a, overrun_a, busy_a;
  logic rx_parity_err_b, rx_frame_err_b, rx_break_b, rx_valid_b, overrun_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_data(rx_data_a),
    .rx_parity_err(rx_parity_err_a), .rx_frame_err(rx_frame_err_a),
    .rx_break(rx_break_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .overrun(overrun_a), .busy(busy_a)
  );

  uart_rx_core #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_data(rx_data_b),
    .rx_parity_err(rx_parity_err_b), .rx_frame_err(rx_frame_err_b),
    .rx_break(rx_break_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .overrun(overrun_b), .busy(busy_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Observed handshakes and overrun pulses (written only by the monitor).
  logic [10:0] obs_a [512];
  logic [10:0] obs_b [512];
  int obs_na = 0, obs_nb = 0, ovr_na = 0, ovr_nb = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rx_valid_a && rx_ready_a && obs_na < 512) begin
        obs_a[obs_na] = {rx_break_a, rx_frame_err_a, rx_parity_err_a, rx_data_a};
        obs_na++;
      end
      if (rx_valid_b && rx_ready_b && obs_nb < 512) begin
        obs_b[obs_nb] = {rx_break_b, rx_frame_err_b, rx_parity_err_b, rx_data_b};
        obs_nb++;
      end
      if (overrun_a) ovr_na++;
      if (overrun_b) ovr_nb++;
    end
  end

  // Consumer ready for DUT A: 0 = hold off, 1 = always ready, 2 = random.
  initial forever begin
    @(posedge clk);
    #1;
    rx_ready_a = (rdy_mode_a == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode_a == 1);
  end

  // Reference model state: expected entries not yet matched, expected overruns.
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];
  int rd_a = 0, rd_b = 0, exp_ovr_a = 0, exp_ovr_b = 0;

  // Expected FIFO entry {brk, ferr, perr, data} from the frame contents.
  function automatic logic [10:0] exp_entry(input bit has_par, input logic [7:0] d,
                                            input logic pbit, input logic stop_v);
    int  ones;
    logic perr, ferr, brk;
    ones = $countones(d) + ((has_par && pbit) ? 1 : 0);
    perr = has_par && (ones % 2 != 0);
    ferr = !stop_v;
    brk  = ferr && (ones == 0);
    return {brk, ferr, perr, d};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit line, input logic v, input int n);
    if (line) rxd_b = v;
    else      rxd_a = v;
    wait_clk(n);
  endtask

  task automatic send_frame(input bit line, input logic [7:0] d, input logic pbit,
                            input logic stop_v);
    logic [10:0] e;
    int occ;
    e = exp_entry(line, d, pbit, stop_v);
    if (!line) begin
      occ = exp_a.size() - (obs_na - rd_a);
      if (occ >= DEPTH) exp_ovr_a++;
      else              exp_a.push_back(e);
    end else begin
      occ = exp_b.size() - (obs_nb - rd_b);
      if (occ >= DEPTH) exp_ovr_b++;
      else              exp_b.push_back(e);
    end
    drive(line, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(line, d[i], BIT_CLK);
    if (line) drive(line, pbit, BIT_CLK);
    drive(line, stop_v, BIT_CLK);
    drive(line, 1'b1, BIT_CLK / 2);
  endtask

  task automatic drain(input bit line, input string tag);
    logic [10:0] e;
    if (!line) begin
      chk({tag, "_count"}, 32'(obs_na - rd_a), 32'(exp_a.size()));
      while (rd_a < obs_na && exp_a.size() > 0) begin
        e = exp_a.pop_front();
        chk(tag, 32'(obs_a[rd_a]), 32'(e));
        rd_a++;
      end
      rd_a = obs_na;
      exp_a.delete();
    end else begin
      chk({tag, "_count"}, 32'(obs_nb - rd_b), 32'(exp_b.size()));
      while (rd_b < obs_nb && exp_b.size() > 0) begin
        e = exp_b.pop_front();
        chk(tag, 32'(obs_b[rd_b]), 32'(e));
        rd_b++;
      end
      rd_b = obs_nb;
      exp_b.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid_a), 32'(0));
    chk({tag, "_busy"},  32'(busy_a), 32'(0));
    chk({tag, "_data"},  32'(rx_data_a), 32'(0));
    chk({tag, "_flags"}, 32'({rx_break_a, rx_frame_err_a, rx_parity_err_a}), 32'(0));
    chk({tag, "_ovr"},   32'(overrun_a), 32'(0));
    chk({tag, "_b"},     32'({rx_valid_b, busy_b, overrun_b, rx_data_b}), 32'(0));
  endtask

  initial begin
    int ovr_base;
    logic [7:0] d;
    logic sv;

    wait_clk(3);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    wait_clk(BIT_CLK);

    // 8N1 0x55; busy is high mid-frame and low once the stop bit resolved.
    fork
      begin
        wait_clk(5 * BIT_CLK);
        chk("t1_busy_mid", 32'(busy_a), 32'(1));
      end
      send_frame(1'b0, 8'h55, 1'b0, 1'b1);
    join
    chk("t1_busy_end", 32'(busy_a), 32'(0));
    wait_clk(BIT_CLK);
    drain(1'b0, "t1");
    chk("t1_valid_low", 32'(rx_valid_a), 32'(0));

    // Even parity 0xA3: parity bit 1 is wrong, 0 is right.
    send_frame(1'b1, 8'hA3, 1'b1, 1'b1);
    send_frame(1'b1, 8'hA3, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    drain(1'b1, "t2");

    // 60-clk glitch is a false start; then a clean 0x3C.
    drive(1'b0, 1'b0, 60);
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    chk("t3_busy", 32'(busy_a), 32'(0));
    chk("t3_valid", 32'(rx_valid_a), 32'(0));
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    drain(1'b0, "t3");

    // Line held low for three frame times: exactly one break entry.
    exp_a.push_back(exp_entry(1'b0, 8'h00, 1'b0, 1'b0));
    drive(1'b0, 1'b0, 30 * BIT_CLK);
    chk("t4_busy_held", 32'(busy_a), 32'(1));
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    chk("t4_busy_idle", 32'(busy_a), 32'(0));
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    drain(1'b0, "t4");

    // Five frames into a 4-deep FIFO with no consumer.
    rdy_mode_a = 0;
    wait_clk(4);
    ovr_base = ovr_na;
    for (int v = 1; v <= 5; v++) begin
      send_frame(1'b0, 8'(v), 1'b0, 1'b1);
      if (v == 4) chk("t5_ovr_before", 32'(ovr_na - ovr_base), 32'(0));
    end
    chk("t5_ovr", 32'(ovr_na - ovr_base), 32'(exp_ovr_a));
    chk("t5_valid_held", 32'(rx_valid_a), 32'(1));
    rdy_mode_a = 1;
    wait_clk(20);
    drain(1'b0, "t5");
    chk("t5_valid_after", 32'(rx_valid_a), 32'(0));

    // Reset in the middle of data bit 3 of 0x7E, then 0x99.
    drive(1'b0, 1'b0, BIT_CLK);
    drive(1'b0, 1'b0, BIT_CLK);
    drive(1'b0, 1'b1, BIT_CLK);
    drive(1'b0, 1'b1, BIT_CLK);
    drive(1'b0, 1'b1, BIT_CLK / 2);
    chk("t6_busy_pre", 32'(busy_a), 32'(1));
    rst_n = 1'b0;
    wait_clk(3);
    chk_reset_outputs("t6_rst");
    rxd_a = 1'b1;
    rst_n = 1'b1;
    wait_clk(2 * BIT_CLK);
    send_frame(1'b0, 8'h99, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    drain(1'b0, "t6");

    // Random frames on A with a random consumer and occasional bad stop bits.
    rdy_mode_a = 2;
    for (int k = 0; k < 8; k++) begin
      d  = 8'($urandom);
      sv = ($urandom_range(0, 4) != 0);
      send_frame(1'b0, d, 1'b0, sv);
    end
    rdy_mode_a = 1;
    wait_clk(BIT_CLK);
    drain(1'b0, "rnd_a");

    // Random frames on B with random parity bits.
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      send_frame(1'b1, d, 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_clk(BIT_CLK);
    drain(1'b1, "rnd_b");

    chk("ovr_total_a", 32'(ovr_na), 32'(exp_ovr_a));
    chk("ovr_total_b", 32'(ovr_nb), 32'(exp_ovr_b));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
